ring_counter_freq: RTL and testbench
====================================

// Module: ring_counter_freq
// PURPOSE
//  One-hot ring counter that rotates at a rate set by an internal clock prescaler.
//  It gives a slow, visible "walking bit" pattern, for example for LED chasers or
//  phase/strobe selection.
//  mode selects the rotation direction.
//  It is a leaf block with a single clock domain and no handshakes.
// PARAMETERS
//  WIDTH  8  Ring length in bits. Sets the width of cnt. Must be >= 2.
//  DIV    4  Prescale ratio: the ring advances once every DIV mclk cycles. Must be >= 1
//            (DIV=1 advances every cycle). Out-of-range values are an elaboration error.
// PORTS
//  mclk  in   1      System clock. All state updates on the rising edge.
//  rst   in   1      Reset, synchronous and active-high.
//  mode  in   1      Direction. 0 = rotate left (toward MSB); 1 = rotate right (toward LSB).
//  cnt   out  WIDTH  One-hot ring state. Registered output.
// BEHAVIOUR
//  Reset (rst=1 at a rising edge of mclk):
//   - cnt <= {{WIDTH-1{1'b0}},1'b1} (8'h01).
//   - Prescaler counter <= 0.
//   - rst has priority over every other condition.
//  Prescaler:
//   - Register pre, width clog2(DIV) (minimum 1 bit).
//   - Each edge: if pre == DIV-1, then pre <= 0 and tick = 1; otherwise pre <= pre + 1.
//   - tick is internal only.
//   - The first advance occurs on the DIV-th rising edge after the edge where rst is
//     sampled low.
//  Advance (on a tick edge):
//   - mode=0: cnt <= {cnt[WIDTH-2:0], cnt[WIDTH-1]}. With WIDTH=8: 01 -> 02 -> ... -> 80 -> 01.
//   - mode=1: cnt <= {cnt[0], cnt[WIDTH-1:1]}. With WIDTH=8: 01 -> 80 -> 40 -> ... -> 02 -> 01.
//   - mode is sampled only on tick edges. Changing mode between ticks never resets pre
//     and never moves cnt.
//   - Full loop period = WIDTH*DIV mclk cycles.
//  Non-tick edges: cnt holds its value.
//  Illegal-state recovery:
//   - An illegal state is cnt not exactly one-hot (zero, or two or more bits set).
//   - On the next tick edge, cnt <= 8'h01 regardless of mode.
//   - Illegal states are never rotated.
//  Unknown/X handling: the mode value before the first tick is don't-care. Only a mode
//   that is valid at a tick edge affects cnt.
//  There is no enable, carry-out or terminal-count output.
// TESTING
//  1. rst=1 for 1 edge, then 0, mode=0, DIV=4:
//     - cnt=01 for edges 1-3 after release; 02 after edge 4; 04 after edge 8.
//     - 80 after edge 28; 01 after edge 32.
//  2. Reset, then mode=1, DIV=4:
//     - cnt=01 -> 80 after 4 edges; 40 after 8 edges; back to 01 after 32 edges.
//  3. Reset mid-operation (cnt=10, pre=2), pulse rst for 1 edge:
//     - cnt=01 the same edge.
//     - Next advance to 02 exactly 4 edges after release.
//  4. mode toggled 0->1 at pre=1 with cnt=04:
//     - cnt holds 04 until the tick edge, then becomes 02. No extra or skipped steps.
//  5. Force cnt=8'h00, then cnt=8'h11:
//     - Each becomes 01 at the next tick, for both mode values.
//  6. DIV=1, mode=0:
//     - cnt advances every edge: 01, 02, 04, ..., 80, 01 over 8 edges.

Source files
------------

// File: rtl/ring_counter_freq.sv
// One-hot walking-bit ring counter advanced by an internal prescaler tick.
// Direction is chosen by mode at each tick; corrupted states recover to bit 0.
module ring_counter_freq #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DIV   = 4
) (
  input  logic             mclk,
  input  logic             rst,
  input  logic             mode,
  output logic [WIDTH-1:0] cnt
);

  localparam int unsigned PW = (DIV > 1) ? $clog2(DIV) : 1;

  if (WIDTH < 2 || DIV < 1) begin : g_bad_param
    $error("ring_counter_freq: WIDTH must be >= 2 and DIV >= 1");
  end

  logic [PW-1:0]    r_pre;
  logic [WIDTH-1:0] r_cnt;
  logic             w_tick;
  logic [PW-1:0]    w_pre_nxt;
  logic [WIDTH-1:0] w_cnt_nxt;

  // Prescaler wraps at DIV-1; the wrap edge is the advance edge.
  always_comb begin
    w_tick    = (r_pre == PW'(DIV - 1));
    w_pre_nxt = w_tick ? '0 : r_pre + PW'(1);
  end

  // Ring next state: hold between ticks, reseed if not exactly one-hot.
  always_comb begin
    w_cnt_nxt = r_cnt;
    if (w_tick) begin
      if (!$onehot(r_cnt)) begin
        w_cnt_nxt = WIDTH'(1);
      end else if (mode) begin
        w_cnt_nxt = {r_cnt[0], r_cnt[WIDTH-1:1]};
      end else begin
        w_cnt_nxt = {r_cnt[WIDTH-2:0], r_cnt[WIDTH-1]};
      end
    end
  end

  always_ff @(posedge mclk) begin
    if (rst) begin
      r_pre <= '0;
      r_cnt <= WIDTH'(1);
    end else begin
      r_pre <= w_pre_nxt;
      r_cnt <= w_cnt_nxt;
    end
  end

  assign cnt = r_cnt;

endmodule

// File: tb/tb_ring_counter_freq.sv
// Bench for ring_counter_freq: DIV=4 and DIV=1 instances against a positional
// model (bit index + edge count), plus literal checkpoints from hand analysis.
module tb_ring_counter_freq;

  localparam int unsigned W = 8;

  logic         mclk;
  logic         rst;
  logic         mode;
  logic [W-1:0] cnt4;
  logic [W-1:0] cnt1;

  int total = 0;
  int bad   = 0;

  ring_counter_freq #(.WIDTH(W), .DIV(4)) u_d4 (
    .mclk(mclk), .rst(rst), .mode(mode), .cnt(cnt4)
  );
  ring_counter_freq #(.WIDTH(W), .DIV(1)) u_d1 (
    .mclk(mclk), .rst(rst), .mode(mode), .cnt(cnt1)
  );

  initial mclk = 1'b0;
  always #5 mclk = ~mclk;

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: bit position, edges since reset, and an injected illegal value.
  bit           m_valid = 1'b0;
  int           m4_pos, m4_k, m1_pos, m1_k;
  bit           m4_bad;
  logic [W-1:0] m4_badval;

  function automatic int rot(input int pos, input logic md);
    return md ? (pos + W - 1) % W : (pos + 1) % W;
  endfunction

  always @(posedge mclk) begin
    if (rst) begin
      m_valid = 1'b1;
      m4_pos = 0; m4_k = 0; m4_bad = 1'b0;
      m1_pos = 0; m1_k = 0;
    end else if (m_valid) begin
      m4_k++;
      if (m4_k % 4 == 0) begin
        if (m4_bad) begin
          m4_bad = 1'b0;
          m4_pos = 0;
        end else begin
          m4_pos = rot(m4_pos, mode);
        end
      end
      m1_k++;
      m1_pos = rot(m1_pos, mode);
    end
  end

  function automatic logic [W-1:0] exp4();
    return m4_bad ? m4_badval : W'(1 << m4_pos);
  endfunction

  // Every-cycle comparison on the falling edge.
  always @(negedge mclk) begin
    if (m_valid) begin
      chk("model_d4", cnt4, exp4());
      chk("model_d1", cnt1, W'(1 << m1_pos));
    end
  end

  // Advance n rising edges; inputs change 2 time units after the edge.
  task automatic step(input int n);
    repeat (n) @(posedge mclk);
    #2;
  endtask

  // Corrupt the DIV=4 ring right after a tick; it must hold until the next tick.
  task automatic inject(input logic [W-1:0] v, input logic md);
    mode = md;
    force u_d4.r_cnt = v;
    m4_bad    = 1'b1;
    m4_badval = v;
    step(1);
    release u_d4.r_cnt;
    chk("illegal_hold1", cnt4, v);
    step(2);
    chk("illegal_hold3", cnt4, v);
    step(1);
    chk("illegal_recover", cnt4, 8'h01);
  endtask

  initial begin
    rst  = 1'b1;
    mode = 1'b0;
    step(1);
    rst = 1'b0;
    chk("reset_d4", cnt4, 8'h01);
    chk("reset_d1", cnt1, 8'h01);

    // Left rotation, DIV=4 and DIV=1 checkpoints.
    for (int e = 1; e <= 32; e++) begin
      step(1);
      case (e)
        1:  chk("d1_e1", cnt1, 8'h02);
        3:  chk("left_e3", cnt4, 8'h01);
        4:  chk("left_e4", cnt4, 8'h02);
        7:  chk("d1_e7", cnt1, 8'h80);
        8:  begin chk("left_e8", cnt4, 8'h04); chk("d1_e8", cnt1, 8'h01); end
        28: chk("left_e28", cnt4, 8'h80);
        32: chk("left_e32", cnt4, 8'h01);
        default: ;
      endcase
    end

    // Right rotation.
    rst = 1'b1; mode = 1'b1;
    step(1);
    rst = 1'b0;
    step(4);  chk("right_e4", cnt4, 8'h80);
    step(4);  chk("right_e8", cnt4, 8'h40);
    step(24); chk("right_e32", cnt4, 8'h01);

    // Reset mid-operation at cnt=10, pre=2.
    rst = 1'b1; mode = 1'b0;
    step(1);
    rst = 1'b0;
    step(18); chk("mid_pre", cnt4, 8'h10);
    rst = 1'b1;
    step(1);  chk("mid_reset", cnt4, 8'h01);
    rst = 1'b0;
    step(3);  chk("mid_hold", cnt4, 8'h01);
    step(1);  chk("mid_adv", cnt4, 8'h02);

    // Direction change between ticks.
    step(4);  chk("dir_at04", cnt4, 8'h04);
    step(1);
    mode = 1'b1;
    step(2);  chk("dir_hold", cnt4, 8'h04);
    step(1);  chk("dir_tick", cnt4, 8'h02);
    step(4);  chk("dir_next", cnt4, 8'h01);

    // Illegal-state recovery in both directions.
    inject(8'h00, 1'b0);
    inject(8'h00, 1'b1);
    inject(8'h11, 1'b0);
    inject(8'h11, 1'b1);
    mode = 1'b0;
    step(4);  chk("post_recover", cnt4, 8'h02);

    step(1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
